// File: rtl/serial_slave_mem.sv
// Bit-serial memory slave: address frame, ACK/NACK against MEM_DEPTH, then one LSB-first data word.
// Define SLAVE_BURST_EN to keep streaming auto-incremented words while AD_SEL stays high.
module serial_slave_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  AD_SEL,
  input  logic                  B_RW,
  input  logic                  B_BUS_OUT,
  output logic                  B_BUS_IN,
  output logic                  B_ACK,
  output logic                  B_SBSY,
  output logic                  B_READY,
  output logic                  S_DVALID,
  output logic [DATA_WIDTH-1:0] S_DOUT,
  output logic [ADDR_WIDTH-1:0] S_DADDR
);

  localparam int CNT_W  = $clog2((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = ADDR_WIDTH'(MEM_DEPTH - 1);
`ifdef SLAVE_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WRITE, ACK_W, READ} state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s, full_addr_s, addr_inc_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [DATA_WIDTH-2:0]   wr_sh_r, wr_sh_s;
  logic [DATA_WIDTH-2:0]   rd_sh_r, rd_sh_s;
  logic [DATA_WIDTH-1:0]   wr_word_s, rd_word_s;
  logic [MEM_AW-1:0]       rd_idx_s;
  logic                    hold_r, hold_s;
  logic                    bus_in_r, bus_in_s, ack_r, ack_s, dvalid_r, dvalid_s;
  logic                    sbsy_r, ready_r, mem_we_s;
  logic [DATA_WIDTH-1:0]   dout_r, dout_s;
  logic [ADDR_WIDTH-1:0]   daddr_r, daddr_s;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  // Bits arrive LSB first and are shifted in from the top, so bit 0 lands last-to-first.
  assign full_addr_s = {B_BUS_OUT, addr_r[ADDR_WIDTH-1:1]};
  assign wr_word_s   = {B_BUS_OUT, wr_sh_r};
  assign addr_inc_s  = (addr_r == ADDR_TOP) ? {ADDR_WIDTH{1'b0}} : addr_r + ADDR_WIDTH'(1);
  assign rd_idx_s    = (state_r == READ && cnt_r == DATA_LAST) ? addr_inc_s[MEM_AW-1:0]
                                                              : addr_r[MEM_AW-1:0];
  assign rd_word_s   = mem_r[rd_idx_s];

  assign B_BUS_IN = bus_in_r;
  assign B_ACK    = ack_r;
  assign B_SBSY   = sbsy_r;
  assign B_READY  = ready_r;
  assign S_DVALID = dvalid_r;
  assign S_DOUT   = dout_r;
  assign S_DADDR  = daddr_r;

  // Next-state and next-output logic; hold blocks a restart until AD_SEL has been seen low.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    cnt_s    = cnt_r;
    wr_sh_s  = wr_sh_r;
    rd_sh_s  = rd_sh_r;
    hold_s   = AD_SEL ? hold_r : 1'b0;
    bus_in_s = 1'b0;
    ack_s    = 1'b0;
    dvalid_s = 1'b0;
    dout_s   = dout_r;
    daddr_s  = daddr_r;
    mem_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (AD_SEL && !hold_r) begin
          addr_s  = full_addr_s;
          cnt_s   = CNT_W'(1);
          state_s = ADDR;
        end else begin
          cnt_s = {CNT_W{1'b0}};
        end
      end
      ADDR: begin
        if (!AD_SEL) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == ADDR_LAST) begin
          addr_s  = full_addr_s;
          cnt_s   = {CNT_W{1'b0}};
          ack_s   = in_range(full_addr_s);
          state_s = ACK_A;
        end else begin
          addr_s = full_addr_s;
          cnt_s  = cnt_r + CNT_W'(1);
        end
      end
      ACK_A: begin
        if (!AD_SEL) begin
          state_s = IDLE;
        end else if (!in_range(addr_r)) begin
          state_s = IDLE;
          hold_s  = 1'b1;
        end else if (B_RW) begin
          state_s = WRITE;
        end else begin
          state_s  = READ;
          bus_in_s = rd_word_s[0];
          rd_sh_s  = rd_word_s[DATA_WIDTH-1:1];
        end
      end
      WRITE: begin
        if (!AD_SEL) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DATA_LAST) begin
          wr_sh_s  = wr_word_s[DATA_WIDTH-1:1];
          cnt_s    = {CNT_W{1'b0}};
          mem_we_s = 1'b1;
          ack_s    = 1'b1;
          dvalid_s = 1'b1;
          dout_s   = wr_word_s;
          daddr_s  = addr_r;
          state_s  = ACK_W;
        end else begin
          wr_sh_s = wr_word_s[DATA_WIDTH-1:1];
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ACK_W: begin
        if (AD_SEL && BURST) begin
          addr_s  = addr_inc_s;
          state_s = WRITE;
        end else begin
          hold_s  = AD_SEL;
          state_s = IDLE;
        end
      end
      READ: begin
        if (!AD_SEL) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DATA_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          if (BURST) begin
            addr_s   = addr_inc_s;
            bus_in_s = rd_word_s[0];
            rd_sh_s  = rd_word_s[DATA_WIDTH-1:1];
          end else begin
            hold_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          bus_in_s = rd_sh_r[0];
          rd_sh_s  = rd_sh_r >> 1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      wr_sh_r  <= {(DATA_WIDTH-1){1'b0}};
      rd_sh_r  <= {(DATA_WIDTH-1){1'b0}};
      hold_r   <= 1'b0;
      bus_in_r <= 1'b0;
      ack_r    <= 1'b0;
      dvalid_r <= 1'b0;
      sbsy_r   <= 1'b0;
      ready_r  <= 1'b0;
      dout_r   <= {DATA_WIDTH{1'b0}};
      daddr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      cnt_r    <= cnt_s;
      wr_sh_r  <= wr_sh_s;
      rd_sh_r  <= rd_sh_s;
      hold_r   <= hold_s;
      bus_in_r <= bus_in_s;
      ack_r    <= ack_s;
      dvalid_r <= dvalid_s;
      sbsy_r   <= (state_s != IDLE);
      ready_r  <= (state_s == IDLE);
      dout_r   <= dout_s;
      daddr_r  <= daddr_s;
    end
  end

  // Word storage; deliberately untouched by reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[addr_r[MEM_AW-1:0]] <= wr_word_s;
    end
  end

endmodule

// File: doc/serial_slave_mem.md
Name: serial_slave_mem

Overview:
Parametrised serial-bus memory slave and next-generation bus slave for the serial bus fabric. It takes a bit-serial address frame, ACKs or NACKs it against the memory range, then serially writes or reads DATA_WIDTH-bit words, LSB first. Word width, depth and address-frame width are generic. It adds out-of-range NACK, clean abort on AD_SEL drop, and an optional auto-incrementing burst mode.

Parameters:
DATA_WIDTH, 8, bits per memory word and per serial data phase
MEM_DEPTH, 2048, number of words; must be ≤ 2**ADDR_WIDTH
ADDR_WIDTH, 12, bits in the serial address frame

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  reset; synchronous and active-high
AD_SEL  input  1  slave select from arbiter/decoder; high for the whole transaction
B_RW  input  1  direction, sampled in ACK_A: 1 = write, 0 = read
B_BUS_OUT  input  1  serial master-to-slave line (address, write data)
B_BUS_IN  output  1  serial slave-to-master line (read data)
B_ACK  output  1  address/write acknowledge
B_SBSY  output  1  slave busy
B_READY  output  1  slave idle and able to accept a transaction
S_DVALID  output  1  one-cycle pulse per committed write word
S_DOUT  output  DATA_WIDTH  last committed write word
S_DADDR  output  ADDR_WIDTH  address of last committed write word

Behaviour:
- States: IDLE, ADDR, ACK_A, WRITE, ACK_W, READ. All outputs are registered.
- RST high at an edge: state=IDLE and counters=0. All outputs read 0, including B_READY. Memory contents are not affected by RST.
- The first edge with RST low registers B_READY=1. B_READY is 1 only in IDLE. B_SBSY is 1 in every state except IDLE.
- IDLE: on an edge with AD_SEL=1, capture B_BUS_OUT as address bit 0 and go to ADDR.
- ADDR: capture one bit per edge into bits 1..ADDR_WIDTH-1. After the last bit, go to ACK_A. The address takes ADDR_WIDTH edges in total.
- ACK_A, one cycle:
  - If address < MEM_DEPTH, B_ACK=1, latch B_RW, and go to WRITE (B_RW=1) or READ (B_RW=0).
  - Otherwise B_ACK stays 0 (NACK) and the block returns to IDLE. No memory access occurs.
- WRITE: sample B_BUS_OUT into bit k of a shift register on DATA_WIDTH edges, k=0..DATA_WIDTH-1. After the last bit, go to ACK_W.
- ACK_W, one cycle:
  - Commit the word to mem[addr].
  - B_ACK=1 and S_DVALID=1 for that cycle.
  - S_DOUT=word and S_DADDR=addr, both held until the next commit.
  - Then go to IDLE (see the Optional Feature for burst).
- READ: drive B_BUS_IN = mem[addr][k] in the k-th READ cycle, k=0..DATA_WIDTH-1, with no gap after ACK_A. After the last bit, go to IDLE, with B_BUS_IN=0.
- Abort: AD_SEL=0 at any edge in ADDR, ACK_A, WRITE, ACK_W or READ sends the block to IDLE. A partial write word is discarded: no commit and no S_DVALID. A word whose ACK_W cycle has already happened stays committed.
- B_BUS_IN is 0 in every state except READ.
- The bit counter is sized as clog2(max(ADDR_WIDTH, DATA_WIDTH))+1. The address counter is ADDR_WIDTH bits.
- Write and read never overlap, so no read-during-write hazard exists.

Optional Feature:
Macro SLAVE_BURST_EN.
- Defined, write burst: if AD_SEL=1 in ACK_W, set addr ← addr+1 and return to WRITE for the next word.
- Defined, read burst: if AD_SEL=1 on the last READ bit, set addr ← addr+1 and continue READ at bit 0 with no gap cycle.
- Defined, wrap: addr equal to MEM_DEPTH-1 wraps to 0.
- Defined, termination: the burst ends when AD_SEL drops, using the abort rules.
- Not defined: exactly one word per transaction. After ACK_W or the last READ bit the block returns to IDLE regardless of AD_SEL, and waits in IDLE for AD_SEL low then high again.

Test Plan:
All scenarios use the default parameters.
1. Write 0xA5 to addr 0x010 → B_ACK in ACK_A and ACK_W; S_DVALID for one cycle with S_DOUT=0xA5 and S_DADDR=0x010; then B_READY=1.
2. Read addr 0x010 after test 1 → B_ACK in ACK_A; B_BUS_IN = 1,0,1,0,0,1,0,1 over 8 cycles; then IDLE.
3. Address 0x900 (≥2048), write → B_ACK stays 0 and the block returns to IDLE; a later read of 0x100 shows the memory unchanged.
4. With SLAVE_BURST_EN, write 0x11 then 0x22 starting at 0x7FF → two S_DVALID pulses with S_DADDR 0x7FF then 0x000. Read-back burst returns 0x11, 0x22. Without the macro, only 0x7FF is written.
5. Drop AD_SEL after 4 bits of write data to 0x020 → IDLE next cycle, no S_DVALID, mem[0x020] unchanged.
6. Assert RST for one cycle mid-READ → all outputs 0 on that edge, B_READY=1 one cycle after release, and a new transaction completes normally.
